// File: rtl/alloc_arbiter_pkg.sv
// Shared configuration for the ReadPipeline allocation front-end.
// N_ICFG: number of requesting input configs.
// ALLOC_INFLIGHT: default depth of the in-order outstanding-allocation FIFO.
package TauCfg;
  localparam int N_ICFG         = 3;
  localparam int ALLOC_INFLIGHT = 8;
endpackage

// File: rtl/alloc_arbiter_inflight.sv
// inflight_fifo: in-order store of granted allocation ids awaiting retire.
// Latency: a pushed id is visible at o_head_dat on the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle; pop on empty is ignored.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_push_dat  write request and id
//   i_pop               remove head entry
//   o_head_dat          oldest entry
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries (0..DEPTH)
module inflight_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rptr];

  // A simultaneous pop frees the head slot, so a push into a full FIFO is safe.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers are exactly AW bits wide; DEPTH is a power of two so they wrap on overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: entries are only read behind a valid count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_dat;
  end
endmodule

// File: rtl/alloc_arbiter.sv
// alloc_arbiter: round-robin front end sharing one Allocator alloc port, with in-order free and block-done sequencing.
// Latency: request -> o_alloc_rdy 1 cycle; ack -> o_req_ack same cycle; retire -> o_free_dval 1 cycle.
// Backpressure: no new grant while FIFO full, block-end latched, or a grant is waiting for i_alloc_ack.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_rdy[N_ICFG]             per-config request, held until acked
//   o_req_ack[N_ICFG]             one-hot ack, combinational with i_alloc_ack
//   o_alloc_rdy, o_alloc_id       grant offered to the Allocator (registered)
//   i_alloc_ack                   Allocator accepted the grant
//   i_retire_dval                 oldest outstanding allocation consumed
//   i_blkend_dval                 no further requests in this block
//   o_free_dval, o_free_id        free issued to the Allocator (registered)
//   o_blkdone_dval                block fully drained
//   o_err                         sticky protocol error
module alloc_arbiter #(
  parameter int N_ICFG  = TauCfg::N_ICFG,
  parameter int DEPTH   = TauCfg::ALLOC_INFLIGHT,
  parameter int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_ICFG-1:0]  i_req_rdy,
  output logic [N_ICFG-1:0]  o_req_ack,
  output logic               o_alloc_rdy,
  input  logic               i_alloc_ack,
  output logic [ICFG_BW-1:0] o_alloc_id,
  input  logic               i_retire_dval,
  input  logic               i_blkend_dval,
  output logic               o_free_dval,
  output logic [ICFG_BW-1:0] o_free_id,
  output logic               o_blkdone_dval,
  output logic               o_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             r_state;
  logic               r_alloc_rdy;
  logic [ICFG_BW-1:0] r_alloc_id;
  logic [ICFG_BW-1:0] r_last_grant;
  logic               r_blkend;
  logic               r_free_dval;
  logic [ICFG_BW-1:0] r_free_id;
  logic               r_err;

  logic               w_push;
  logic               w_pop;
  logic [ICFG_BW-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic               w_can_grant;
  logic [ICFG_BW-1:0] w_pick;
  logic               w_blkdone;

  // First requester strictly after the previous winner, wrapping modulo N_ICFG.
  function automatic logic [ICFG_BW-1:0] f_rr_pick(
    input logic [N_ICFG-1:0]  req,
    input logic [ICFG_BW-1:0] last
  );
    logic [ICFG_BW-1:0] win;
    logic               found;
    logic [N_ICFG-1:0]  shifted;
    int                 idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_ICFG; i++) begin
      idx     = (int'(last) + i) % N_ICFG;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        win   = ICFG_BW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_pick      = f_rr_pick(i_req_rdy, r_last_grant);
  assign w_can_grant = (|i_req_rdy) && (w_count < CW'(DEPTH)) && !r_blkend;
  assign w_push      = (r_state == HOLD) && i_alloc_ack;
  assign w_pop       = i_retire_dval && !w_empty;

  // Holding off on a free this cycle orders the last capacity restore ahead of the cursor reset.
  assign w_blkdone   = r_blkend && (r_state == IDLE) && w_empty && !r_free_dval;

  assign o_req_ack      = w_push ? (N_ICFG'(1) << r_alloc_id) : '0;
  assign o_alloc_rdy    = r_alloc_rdy;
  assign o_alloc_id     = r_alloc_id;
  assign o_free_dval    = r_free_dval;
  assign o_free_id      = r_free_id;
  assign o_blkdone_dval = w_blkdone;
  assign o_err          = r_err;

  inflight_fifo #(
    .DEPTH (DEPTH),
    .W     (ICFG_BW)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_push_dat (r_alloc_id),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_alloc_rdy  <= 1'b0;
      r_alloc_id   <= '0;
      r_last_grant <= ICFG_BW'(N_ICFG - 1);
      r_blkend     <= 1'b0;
      r_free_dval  <= 1'b0;
      r_free_id    <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_grant) begin
            r_alloc_id  <= w_pick;
            r_alloc_rdy <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          // Grant completes even if the requester has since dropped its request.
          if (i_alloc_ack) begin
            r_last_grant <= r_alloc_id;
            r_alloc_rdy  <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_alloc_rdy <= 1'b0;
        end
      endcase

      r_free_dval <= w_pop;
      if (w_pop) r_free_id <= w_head;

      if (w_blkdone)          r_blkend <= 1'b0;
      else if (i_blkend_dval) r_blkend <= 1'b1;

      if ((i_retire_dval && w_empty) ||
          (i_blkend_dval && r_blkend) ||
          (w_push && w_full && !w_pop))
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alloc_arbiter.sv
module tb_alloc_arbiter;
  localparam int N  = 3;
  localparam int D  = 2;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  i_req_rdy;
  logic [N-1:0]  o_req_ack;
  logic          o_alloc_rdy;
  logic          i_alloc_ack;
  logic [BW-1:0] o_alloc_id;
  logic          i_retire_dval;
  logic          i_blkend_dval;
  logic          o_free_dval;
  logic [BW-1:0] o_free_id;
  logic          o_blkdone_dval;
  logic          o_err;

  always #5 clk = ~clk;

  alloc_arbiter #(.N_ICFG(N), .DEPTH(D)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req_rdy      (i_req_rdy),
    .o_req_ack      (o_req_ack),
    .o_alloc_rdy    (o_alloc_rdy),
    .i_alloc_ack    (i_alloc_ack),
    .o_alloc_id     (o_alloc_id),
    .i_retire_dval  (i_retire_dval),
    .i_blkend_dval  (i_blkend_dval),
    .o_free_dval    (o_free_dval),
    .o_free_id      (o_free_id),
    .o_blkdone_dval (o_blkdone_dval),
    .o_err          (o_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: grant offer, queue of outstanding ids, block latch, sticky error.
  bit m_rdy, m_blk, m_err, m_fd;
  int m_id, m_last, m_fid;
  int m_q[$];

  bit auto_ack = 1'b0;
  int cnum = 0;
  int fcyc = -1;
  int bdcyc = -1;
  logic [N-1:0] last_ack;
  int glog[$];
  int flog[$];
  bit rdy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick();
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (((i_req_rdy >> idx) & 3'b001) != 3'b000) return idx;
    end
    return 0;
  endfunction

  task automatic model_update();
    bit pop, push, bd;
    int head, cnt_before;
    if (i_rst) begin
      m_rdy = 0; m_id = 0; m_last = N - 1; m_q.delete();
      m_blk = 0; m_err = 0; m_fd = 0; m_fid = 0;
      return;
    end
    bd         = m_blk && !m_rdy && (m_q.size() == 0) && !m_fd;
    cnt_before = m_q.size();
    pop        = i_retire_dval && (m_q.size() > 0);
    push       = m_rdy && i_alloc_ack;
    head       = 0;
    if (i_retire_dval && !pop) m_err = 1;
    if (i_blkend_dval && m_blk) m_err = 1;
    if (pop) head = m_q.pop_front();
    if (push) m_q.push_back(m_id);
    m_fd = pop;
    if (pop) m_fid = head;
    if (m_rdy) begin
      if (i_alloc_ack) begin
        m_last = m_id;
        m_rdy  = 0;
      end
    end else if ((i_req_rdy != 0) && (cnt_before < D) && !m_blk) begin
      m_id  = m_pick();
      m_rdy = 1;
    end
    if (bd) m_blk = 0;
    else if (i_blkend_dval) m_blk = 1;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance.
  task automatic cyc(input logic [N-1:0] req, input logic ack, input logic ret,
                     input logic blk, input logic rst, input bit cmp);
    int exp_ack, exp_bd;
    i_req_rdy     = req;
    i_alloc_ack   = auto_ack ? o_alloc_rdy : ack;
    i_retire_dval = ret;
    i_blkend_dval = blk;
    i_rst         = rst;
    #1;
    if (cmp) begin
      exp_ack = (m_rdy && i_alloc_ack) ? (1 << m_id) : 0;
      exp_bd  = (m_blk && !m_rdy && (m_q.size() == 0) && !m_fd) ? 1 : 0;
      chk("alloc_rdy", 32'(o_alloc_rdy), 32'(m_rdy));
      chk("alloc_id", 32'(o_alloc_id), m_id);
      chk("req_ack", 32'(o_req_ack), exp_ack);
      chk("free_dval", 32'(o_free_dval), 32'(m_fd));
      chk("free_id", 32'(o_free_id), m_fid);
      chk("blkdone", 32'(o_blkdone_dval), exp_bd);
      chk("err", 32'(o_err), 32'(m_err));
    end
    last_ack = o_req_ack;
    for (int k = 0; k < N; k++)
      if (o_req_ack == (3'b001 << k)) glog.push_back(k);
    if (o_free_dval) begin
      flog.push_back(int'(o_free_id));
      fcyc = cnum;
    end
    if (o_blkdone_dval) bdcyc = cnum;
    @(posedge clk);
    model_update();
    cnum++;
    #1;
  endtask

  initial begin
    logic ret;
    logic [N-1:0] rq;
    logic a, r, b, x;

    // Reset
    cyc(3'b000, 0, 0, 0, 1, 0);
    cyc(3'b000, 0, 0, 0, 1, 0);
    chk("rst_alloc_rdy", 32'(o_alloc_rdy), 0);
    chk("rst_alloc_id", 32'(o_alloc_id), 0);
    chk("rst_free_dval", 32'(o_free_dval), 0);
    chk("rst_free_id", 32'(o_free_id), 0);
    chk("rst_blkdone", 32'(o_blkdone_dval), 0);
    chk("rst_err", 32'(o_err), 0);

    // 1: all requesting, retire each grant right after its ack
    auto_ack = 1'b1;
    glog.delete(); flog.delete();
    ret = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(3'b111, 0, ret, 0, 0, 1);
      ret = (last_ack != 3'b000);
    end
    cyc(3'b000, 0, ret, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("t1_ngrants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t1_g0", glog[0], 0);
      chk("t1_g1", glog[1], 1);
      chk("t1_g2", glog[2], 2);
      chk("t1_g3", glog[3], 0);
    end

    // 2/3: fill FIFO with ids 1,2; further request blocked; retire frees head, ack+retire together
    glog.delete(); flog.delete();
    for (int i = 0; i < 4; i++) cyc(3'b110, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b001, 0, 0, 0, 0, 1);
      chk("t2_full_no_rdy", 32'(o_alloc_rdy), 0);
    end
    cyc(3'b001, 0, 1, 0, 0, 1);
    chk("t2_free_dval", 32'(o_free_dval), 1);
    chk("t2_free_id", 32'(o_free_id), 1);
    cyc(3'b001, 0, 0, 0, 0, 1);
    chk("t2_regrant_rdy", 32'(o_alloc_rdy), 1);
    chk("t2_regrant_id", 32'(o_alloc_id), 0);
    cyc(3'b001, 0, 1, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    cyc(3'b000, 0, 1, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("t2_ngrants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t2_g0", glog[0], 1);
      chk("t2_g1", glog[1], 2);
      chk("t2_g2", glog[2], 0);
    end
    chk("t3_nfrees", flog.size(), 3);
    if (flog.size() == 3) begin
      chk("t3_f0", flog[0], 1);
      chk("t3_f1", flog[1], 2);
      chk("t3_f2", flog[2], 0);
    end

    // 4: grant id 1, block end, retire -> free then blkdone next cycle; no grants while latched
    glog.delete(); flog.delete();
    cyc(3'b010, 0, 0, 0, 0, 1);
    cyc(3'b010, 0, 0, 0, 0, 1);
    cyc(3'b000, 0, 0, 1, 0, 1);
    rdy_seen = 1'b0;
    cyc(3'b111, 0, 1, 0, 0, 1); rdy_seen |= o_alloc_rdy;
    cyc(3'b111, 0, 0, 0, 0, 1); rdy_seen |= o_alloc_rdy;
    cyc(3'b111, 0, 0, 0, 0, 1); rdy_seen |= o_alloc_rdy;
    chk("t4_no_grant_latched", 32'(rdy_seen), 0);
    chk("t4_blkdone_after_free", bdcyc, fcyc + 1);
    cyc(3'b111, 0, 0, 0, 0, 1);
    chk("t4_grant_after_done", 32'(o_alloc_id), 2);
    cyc(3'b000, 0, 0, 0, 0, 1);
    cyc(3'b000, 0, 1, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("t4_ngrants", glog.size(), 2);
    if (glog.size() == 2) chk("t4_g0", glog[0], 1);
    chk("t4_err_clear", 32'(o_err), 0);

    // 5a: double block end
    cyc(3'b000, 0, 0, 1, 0, 1);
    cyc(3'b000, 0, 0, 1, 0, 1);
    chk("t5_err_dblend", 32'(o_err), 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("t5_err_sticky", 32'(o_err), 1);

    // 6: reset while HOLD with one outstanding
    cyc(3'b001, 0, 0, 0, 0, 1);
    cyc(3'b001, 0, 0, 0, 0, 1);
    auto_ack = 1'b0;
    cyc(3'b010, 0, 0, 0, 0, 1);
    chk("t6_in_hold", 32'(o_alloc_rdy), 1);
    cyc(3'b010, 0, 0, 0, 1, 1);
    chk("t6_rst_rdy", 32'(o_alloc_rdy), 0);
    chk("t6_rst_id", 32'(o_alloc_id), 0);
    chk("t6_rst_free", 32'(o_free_dval), 0);
    chk("t6_rst_err", 32'(o_err), 0);
    auto_ack = 1'b1;
    cyc(3'b111, 0, 0, 0, 0, 1);
    chk("t6_first_id", 32'(o_alloc_id), 0);
    cyc(3'b000, 0, 0, 0, 0, 1);
    cyc(3'b000, 0, 1, 0, 0, 1);
    chk("t6_free_id", 32'(o_free_id), 0);
    cyc(3'b000, 0, 1, 0, 0, 1);
    chk("t6_fifo_empty_err", 32'(o_err), 1);

    // 5b: retire on empty, after a clean reset
    cyc(3'b000, 0, 0, 0, 1, 1);
    cyc(3'b000, 0, 1, 0, 0, 1);
    chk("t5_no_free", 32'(o_free_dval), 0);
    chk("t5_err_empty", 32'(o_err), 1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("t5_err_held", 32'(o_err), 1);

    // Random traffic against the model
    auto_ack = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rq = 3'($urandom_range(0, 7));
      a  = o_alloc_rdy && ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 24) == 0);
      x  = ($urandom_range(0, 149) == 0);
      cyc(rq, a, r, b, x, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
